// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: opcodes, ALU function
// codes, state encodings and opcode classification helpers.
package alu_ctrl_pkg;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b01001;
  localparam logic [4:0] OPC_OR   = 5'b01010;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_MUL = 4'd4;
  localparam logic [3:0] ALU_DIV = 4'd5;
  localparam logic [3:0] ALU_NEG = 4'd6;
  localparam logic [3:0] ALU_NOT = 4'd7;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  typedef enum logic [2:0] {
    CLS_BIN,
    CLS_UNA,
    CLS_WIDE,
    CLS_HALT,
    CLS_BAD
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] opc);
    op_class_t cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: cls = CLS_BIN;
      OPC_NEG, OPC_NOT:                  cls = CLS_UNA;
      OPC_MUL, OPC_DIV:                  cls = CLS_WIDE;
      OPC_HALT:                          cls = CLS_HALT;
      default:                           cls = CLS_BAD;
    endcase
    return cls;
  endfunction

  function automatic logic [3:0] alu_op_of(input logic [4:0] opc);
    logic [3:0] op;
    case (opc)
      OPC_ADD: op = ALU_ADD;
      OPC_SUB: op = ALU_SUB;
      OPC_AND: op = ALU_AND;
      OPC_OR:  op = ALU_OR;
      OPC_MUL: op = ALU_MUL;
      OPC_DIV: op = ALU_DIV;
      OPC_NEG: op = ALU_NEG;
      OPC_NOT: op = ALU_NOT;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot select; indices past the register file yield
// an all-zero select so no register is ever driven or loaded by mistake.
module reg_sel_decoder #(
  parameter int IDX_W = 4,
  parameter int NUM   = 16
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NUM-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM; i++) begin
      onehot[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Microcoded-style control sequencer: fetches an instruction in T0..T2, then
// steps through per-class execute states emitting Moore control strobes.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OPC_W     = 5,
  parameter int ALU_OP_W  = 4
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic                MemReady,
  input  logic [DATA_W-1:0]   IR,
  output logic                PCout,
  output logic                MDRout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                PCin,
  output logic                MARin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [ALU_OP_W-1:0] AluOp,
  output logic                Done,
  output logic                Illegal,
  output logic                Halted
);

  localparam int HDR_W = OPC_W + 3 * REG_IDX_W;

  logic [3:0]           state;
  logic [3:0]           next_state;
  logic                 t1_seen;
  logic [HDR_W-1:0]     hdr_q;
  logic [HDR_W-1:0]     hdr;
  logic [OPC_W-1:0]     opcode;
  logic [REG_IDX_W-1:0] ra;
  logic [REG_IDX_W-1:0] rb;
  logic [REG_IDX_W-1:0] rc;
  op_class_t            cls;
  logic                 ra_ok;
  logic                 rb_ok;
  logic                 rc_ok;
  logic                 fields_ok;
  logic                 t3_abort;
  logic [3:0]           finish_next;
  logic                 rout_en;
  logic                 rin_en;
  logic [REG_IDX_W-1:0] rout_idx;
  logic [3:0]           alu_sel;
  logic                 ir_unused;

  // The IR register loads at the end of T2, so its fields are first valid in
  // T3; they are captured there so later execute states see a stable copy.
  assign hdr       = (state == S_T3) ? IR[DATA_W-1 -: HDR_W] : hdr_q;
  assign ir_unused = ^IR[DATA_W-HDR_W-1:0];
  assign opcode    = hdr[HDR_W-1 -: OPC_W];
  assign ra        = hdr[HDR_W-OPC_W-1 -: REG_IDX_W];
  assign rb        = hdr[HDR_W-OPC_W-REG_IDX_W-1 -: REG_IDX_W];
  assign rc        = hdr[REG_IDX_W-1:0];
  assign cls       = op_class(opcode);

  assign ra_ok = int'(ra) < NUM_REGS;
  assign rb_ok = int'(rb) < NUM_REGS;
  assign rc_ok = int'(rc) < NUM_REGS;

  always_comb begin
    case (cls)
      CLS_BIN:  fields_ok = ra_ok && rb_ok && rc_ok;
      CLS_UNA:  fields_ok = ra_ok && rb_ok;
      CLS_WIDE: fields_ok = rb_ok && rc_ok;
      default:  fields_ok = 1'b1;
    endcase
  end

  assign t3_abort    = (cls == CLS_BAD) || !fields_ok;
  assign finish_next = Run ? S_T0 : S_IDLE;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state   <= S_IDLE;
      t1_seen <= 1'b0;
      hdr_q   <= '0;
    end else begin
      state   <= next_state;
      t1_seen <= (state == S_T1);
      if (state == S_T3) hdr_q <= IR[DATA_W-1 -: HDR_W];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: next_state = Run ? S_T0 : S_IDLE;
      S_T0:   next_state = S_T1;
      S_T1:   next_state = MemReady ? S_T2 : S_T1;
      S_T2:   next_state = S_T3;
      S_T3: begin
        if (cls == CLS_HALT)  next_state = S_HALT;
        else if (t3_abort)    next_state = finish_next;
        else                  next_state = S_T4;
      end
      S_T4:   next_state = (cls == CLS_UNA) ? finish_next : S_T5;
      S_T5:   next_state = (cls == CLS_WIDE) ? S_T6 : finish_next;
      S_T6:   next_state = finish_next;
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // PC load and Z-low drive are limited to the first T1 cycle so a memory
  // stall never increments the PC twice.
  always_comb begin
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Done     = 1'b0;
    Illegal  = 1'b0;
    Halted   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = rb;
    rin_en   = 1'b0;
    alu_sel  = ALU_NOP;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = !t1_seen;
        Zlowout = !t1_seen;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (cls != CLS_HALT && t3_abort) begin
          Illegal = 1'b1;
        end else if (cls == CLS_BIN || cls == CLS_WIDE) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
        end else if (cls == CLS_UNA) begin
          rout_en = 1'b1;
          Zin     = 1'b1;
          alu_sel = alu_op_of(opcode);
        end
      end
      S_T4: begin
        if (cls == CLS_UNA) begin
          Zlowout = 1'b1;
          rin_en  = 1'b1;
          Done    = 1'b1;
        end else begin
          rout_en  = 1'b1;
          rout_idx = rc;
          Zin      = 1'b1;
          alu_sel  = alu_op_of(opcode);
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_WIDE) begin
          LOin = 1'b1;
        end else begin
          rin_en = 1'b1;
          Done   = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        Done     = 1'b1;
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  assign AluOp = ALU_OP_W'(alu_sel);

  reg_sel_decoder #(
    .IDX_W (REG_IDX_W),
    .NUM   (NUM_REGS)
  ) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_sel_decoder #(
    .IDX_W (REG_IDX_W),
    .NUM   (NUM_REGS)
  ) u_rin_dec (
    .idx    (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed bench for alu_ctrl_sequencer: walks fetch/execute sequences and
// compares every control output against hand-derived values each cycle.
module tb_alu_ctrl_sequencer;

  localparam logic [16:0] C_PCOUT = 17'h10000;
  localparam logic [16:0] C_MDROUT = 17'h08000;
  localparam logic [16:0] C_ZLO   = 17'h04000;
  localparam logic [16:0] C_ZHI   = 17'h02000;
  localparam logic [16:0] C_PCIN  = 17'h01000;
  localparam logic [16:0] C_MARIN = 17'h00800;
  localparam logic [16:0] C_MDRIN = 17'h00400;
  localparam logic [16:0] C_IRIN  = 17'h00200;
  localparam logic [16:0] C_YIN   = 17'h00100;
  localparam logic [16:0] C_ZIN   = 17'h00080;
  localparam logic [16:0] C_HIIN  = 17'h00040;
  localparam logic [16:0] C_LOIN  = 17'h00020;
  localparam logic [16:0] C_INCPC = 17'h00010;
  localparam logic [16:0] C_READ  = 17'h00008;
  localparam logic [16:0] C_DONE  = 17'h00004;
  localparam logic [16:0] C_ILL   = 17'h00002;
  localparam logic [16:0] C_HALT  = 17'h00001;

  localparam logic [16:0] T0_CTRL = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
  localparam logic [16:0] T1_FIRST = C_ZLO | C_PCIN | C_READ | C_MDRIN;
  localparam logic [16:0] T1_STALL = C_READ | C_MDRIN;
  localparam logic [16:0] T2_CTRL = C_MDROUT | C_IRIN;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        Run;
  logic        MemReady;
  logic [31:0] IR;
  logic PCout, MDRout, Zlowout, Zhighout, PCin, MARin, MDRin, IRin;
  logic Yin, Zin, HIin, LOin, IncPC, Read, Done, Illegal, Halted;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic [3:0]  AluOp;
  logic [63:0] obs;

  int total = 0;
  int bad = 0;

  always #5 Clock = ~Clock;

  alu_ctrl_sequencer dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .Run      (Run),
    .MemReady (MemReady),
    .IR       (IR),
    .PCout    (PCout),
    .MDRout   (MDRout),
    .Zlowout  (Zlowout),
    .Zhighout (Zhighout),
    .PCin     (PCin),
    .MARin    (MARin),
    .MDRin    (MDRin),
    .IRin     (IRin),
    .Yin      (Yin),
    .Zin      (Zin),
    .HIin     (HIin),
    .LOin     (LOin),
    .IncPC    (IncPC),
    .Read     (Read),
    .Rout     (Rout),
    .Rin      (Rin),
    .AluOp    (AluOp),
    .Done     (Done),
    .Illegal  (Illegal),
    .Halted   (Halted)
  );

  assign obs = {11'b0, PCout, MDRout, Zlowout, Zhighout, PCin, MARin, MDRin, IRin,
                Yin, Zin, HIin, LOin, IncPC, Read, Done, Illegal, Halted,
                Rout, Rin, AluOp};

  task automatic check_output(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [16:0] ctrl,
                            input logic [15:0] rout, input logic [15:0] rin,
                            input logic [3:0] op);
    check_output(tag, obs, {11'b0, ctrl, rout, rin, op});
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Runs the fetch phase from T0 with no memory stall.
  task automatic fetch(input string tag);
    expect_out({tag, "_t0"}, T0_CTRL, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out({tag, "_t1"}, T1_FIRST, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out({tag, "_t2"}, T2_CTRL, 16'h0, 16'h0, 4'd0);
    tick();
  endtask

  initial begin
    Clear = 1'b1;
    Run = 1'b0;
    MemReady = 1'b1;
    IR = 32'h0;
    tick();
    expect_out("reset", 17'h0, 16'h0, 16'h0, 4'd0);

    // and R5,R2,R4
    Clear = 1'b0;
    Run = 1'b1;
    IR = 32'h4A920000;
    tick();
    fetch("and");
    expect_out("and_t3", C_YIN, 16'h0004, 16'h0, 4'd0);
    tick();
    expect_out("and_t4", C_ZIN, 16'h0010, 16'h0, 4'd2);
    tick();
    expect_out("and_t5", C_ZLO | C_DONE, 16'h0, 16'h0020, 4'd0);
    tick();

    // mul R1,R2,R3 with a three-cycle memory stall and Run dropping mid-way
    IR = 32'h78918000;
    MemReady = 1'b0;
    expect_out("mul_t0", T0_CTRL, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("stall_c1", T1_FIRST, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("stall_c2", T1_STALL, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("stall_c3", T1_STALL, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("stall_c4", T1_STALL, 16'h0, 16'h0, 4'd0);
    MemReady = 1'b1;
    tick();
    expect_out("mul_t2", T2_CTRL, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("mul_t3", C_YIN, 16'h0004, 16'h0, 4'd0);
    tick();
    expect_out("mul_t4", C_ZIN, 16'h0008, 16'h0, 4'd4);
    Run = 1'b0;
    tick();
    expect_out("mul_t5", C_ZLO | C_LOIN, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("mul_t6", C_ZHI | C_HIIN | C_DONE, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("mul_idle", 17'h0, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("idle_hold", 17'h0, 16'h0, 16'h0, 4'd0);

    // Unlisted opcode 11111
    IR = 32'hF8000000;
    Run = 1'b1;
    tick();
    fetch("ill");
    expect_out("ill_t3", C_ILL, 16'h0, 16'h0, 4'd0);
    tick();

    // neg R7,R9 directly after the illegal instruction
    IR = 32'h8BC80000;
    fetch("neg");
    expect_out("neg_t3", C_ZIN, 16'h0200, 16'h0, 4'd6);
    tick();
    expect_out("neg_t4", C_ZLO | C_DONE, 16'h0, 16'h0080, 4'd0);
    tick();

    // halt, then Run toggling must not leave HALT
    IR = 32'hD8000000;
    fetch("halt");
    expect_out("halt_t3", 17'h0, 16'h0, 16'h0, 4'd0);
    tick();
    expect_out("halted_a", C_HALT, 16'h0, 16'h0, 4'd0);
    Run = 1'b0;
    tick();
    expect_out("halted_b", C_HALT, 16'h0, 16'h0, 4'd0);
    Run = 1'b1;
    tick();
    expect_out("halted_c", C_HALT, 16'h0, 16'h0, 4'd0);
    Clear = 1'b1;
    tick();
    expect_out("halt_clear", 17'h0, 16'h0, 16'h0, 4'd0);
    Clear = 1'b0;

    // Clear during T4 of an and, then restart
    IR = 32'h4A920000;
    tick();
    fetch("clr");
    expect_out("clr_t3", C_YIN, 16'h0004, 16'h0, 4'd0);
    tick();
    expect_out("clr_t4", C_ZIN, 16'h0010, 16'h0, 4'd2);
    Clear = 1'b1;
    tick();
    expect_out("clr_idle", 17'h0, 16'h0, 16'h0, 4'd0);
    Clear = 1'b0;
    tick();
    expect_out("restart_t0", T0_CTRL, 16'h0, 16'h0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
